// File: rtl/binary_linear_pkg.sv
// binary_linear_pkg
//   Shared helpers for the binarised fully-connected layer.
//   - clog2        : ceiling log2, never below 1 so it can size any port
//   - pop_w        : width of an XNOR popcount over an in_w-bit vector
//   - score_w      : width of the signed score 2*pop - in_w
//   - score_t      : signed score type for the default 64-bit input width
package binary_linear_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int pop_w(input int in_w);
    return clog2(in_w + 1);
  endfunction

  function automatic int score_w(input int in_w);
    return clog2(in_w + 1) + 1;
  endfunction

  localparam int DEFAULT_IN_W    = 64;
  localparam int DEFAULT_SCORE_W = score_w(DEFAULT_IN_W);

  typedef logic signed [DEFAULT_SCORE_W-1:0] score_t;

endpackage

// File: rtl/binary_linear_xnor_popcount.sv
// xnor_popcount
//   Combinational XNOR-popcount of one weight row against the activation
//   vector. The match bits are summed by a balanced binary adder tree whose
//   leaf count is rounded up to a power of two (spare leaves are zero).
// Ports:
//   weight : IN_W-bit weight row (1=+1, 0=-1)
//   act    : IN_W-bit activation vector (1=+1, 0=-1)
//   pop    : number of positions where weight and act agree
module xnor_popcount
  import binary_linear_pkg::*;
#(
  parameter int IN_W = 64
) (
  input  logic [IN_W-1:0]          weight,
  input  logic [IN_W-1:0]          act,
  output logic [pop_w(IN_W)-1:0]   pop
);

  localparam int PW     = pop_w(IN_W);
  localparam int DEPTH  = clog2(IN_W);
  localparam int LEAVES = 1 << DEPTH;

  logic [IN_W-1:0] match;
  assign match = ~(weight ^ act);

  for (genvar l = 0; l <= DEPTH; l++) begin : lvl
    logic [PW-1:0] sum [LEAVES >> l];
    if (l == 0) begin : leaf
      for (genvar i = 0; i < LEAVES; i++) begin : bit_g
        if (i < IN_W) begin : used
          assign sum[i] = PW'(match[i]);
        end else begin : pad
          assign sum[i] = '0;
        end
      end
    end else begin : add
      for (genvar i = 0; i < (LEAVES >> l); i++) begin : node_g
        assign sum[i] = lvl[l-1].sum[2*i] + lvl[l-1].sum[2*i+1];
      end
    end
  end

  assign pop = lvl[DEPTH].sum[0];

endmodule

// File: rtl/binary_linear_xnor.sv
// binary_linear_xnor
//   Binarised fully-connected layer. Each accepted IN_W-bit sign vector is
//   XNOR-popcounted against the OUT_N weight rows of one block of an internal
//   writable weight RAM; each signed score 2*pop-IN_W is compared against
//   THRESH to give one output bit. Three register stages, one input per
//   cycle, no backpressure. A step counter admits NUM_STEPS inputs per
//   sequence and raises a sticky done together with the last output.
// Optional build macro:
//   BINARY_LINEAR_SCORE_OUT_EN adds score_out carrying the per-neuron
//   signed scores, registered alongside data_out.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : synchronous clear of step_cnt, done and valids
//   data_in           : activations (1=+1, 0=-1), qualified by data_in_valid
//   block_sel         : weight block used for this input
//   w_we/w_addr/w_data: whole-block weight write, row i at [i*IN_W +: IN_W]
//   data_out          : neuron output bits, qualified by data_out_valid
//   step_cnt          : accepted inputs so far (saturates at NUM_STEPS)
//   done              : sticky sequence-complete flag
module binary_linear_xnor
  import binary_linear_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int OUT_N     = 16,
  parameter int NUM_BLK   = 4,
  parameter int NUM_STEPS = 30,
  parameter int THRESH    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic [IN_W-1:0]                  data_in,
  input  logic                             data_in_valid,
  input  logic [clog2(NUM_BLK)-1:0]        block_sel,
  input  logic                             w_we,
  input  logic [clog2(NUM_BLK)-1:0]        w_addr,
  input  logic [OUT_N*IN_W-1:0]            w_data,
  output logic [OUT_N-1:0]                 data_out,
  output logic                             data_out_valid,
  output logic [clog2(NUM_STEPS+1)-1:0]    step_cnt,
  output logic                             done
`ifdef BINARY_LINEAR_SCORE_OUT_EN
  ,
  output logic [OUT_N*score_w(IN_W)-1:0]   score_out
`endif
);

  localparam int BW = clog2(NUM_BLK);
  localparam int CW = clog2(NUM_STEPS + 1);
  localparam int PW = pop_w(IN_W);
  localparam int SW = score_w(IN_W);

  localparam logic [BW:0]          BLK_LIM   = (BW+1)'(NUM_BLK);
  localparam logic [CW-1:0]        STEP_MAX  = CW'(NUM_STEPS);
  localparam logic [CW-1:0]        STEP_LAST = CW'(NUM_STEPS - 1);
  localparam logic signed [SW-1:0] THRESH_S  = SW'(THRESH);

  // 2*pop - IN_W; the concatenation is exactly SW bits and the
  // subtraction wraps correctly in SW-bit two's complement.
  function automatic logic signed [SW-1:0] to_score(input logic [PW-1:0] p);
    return $signed({p, 1'b0}) - $signed(SW'(IN_W));
  endfunction

  function automatic logic above_thresh(input logic signed [SW-1:0] s);
    return s > THRESH_S;
  endfunction

  logic [OUT_N*IN_W-1:0] w_ram [NUM_BLK];

  logic accept;
  logic blk_ok;
  logic wr_ok;

  assign accept = data_in_valid & ~clear & (step_cnt < STEP_MAX);
  assign blk_ok = ({1'b0, block_sel} < BLK_LIM);
  assign wr_ok  = w_we & ({1'b0, w_addr} < BLK_LIM);

  // Nonblocking write gives read-first behaviour for a same-cycle read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      w_ram[w_addr] <= w_data;
    end
  end

  // ---- S1: weight read, activation capture ----
  logic [OUT_N*IN_W-1:0] row_p0;
  logic [IN_W-1:0]       act_p0;
  logic                  blk_ok_p0;
  logic                  last_p0;
  logic                  vld_p0;

  always_ff @(posedge clk) begin
    row_p0    <= blk_ok ? w_ram[block_sel] : '0;
    act_p0    <= data_in;
    blk_ok_p0 <= blk_ok;
    last_p0   <= (step_cnt == STEP_LAST);
  end

  // ---- S2: per-neuron XNOR popcount ----
  logic [PW-1:0] pop_c  [OUT_N];
  logic [PW-1:0] pop_p1 [OUT_N];
  logic          blk_ok_p1;
  logic          last_p1;
  logic          vld_p1;

  for (genvar i = 0; i < OUT_N; i++) begin : neuron_g
    xnor_popcount #(
      .IN_W (IN_W)
    ) u_pop (
      .weight (row_p0[i*IN_W +: IN_W]),
      .act    (act_p0),
      .pop    (pop_c[i])
    );
  end

  always_ff @(posedge clk) begin
    pop_p1    <= pop_c;
    blk_ok_p1 <= blk_ok_p0;
    last_p1   <= last_p0;
  end

  // ---- S3: score and threshold ----
  logic signed [SW-1:0] score_c [OUT_N];
  logic [OUT_N-1:0]     bits_c;

  always_comb begin
    bits_c = '0;
    for (int i = 0; i < OUT_N; i++) begin
      score_c[i] = blk_ok_p1 ? to_score(pop_p1[i]) : '0;
      bits_c[i]  = blk_ok_p1 & above_thresh(score_c[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt       <= '0;
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
      data_out_valid <= 1'b0;
      done           <= 1'b0;
      data_out       <= '0;
    end else begin
      step_cnt       <= clear ? '0 : (accept ? step_cnt + CW'(1) : step_cnt);
      vld_p0         <= accept;
      vld_p1         <= vld_p0 & ~clear;
      data_out_valid <= vld_p1 & ~clear;
      done           <= ~clear & (done | (vld_p1 & last_p1));
      if (vld_p1 & ~clear) begin
        data_out <= bits_c;
      end
    end
  end

`ifdef BINARY_LINEAR_SCORE_OUT_EN
  always_ff @(posedge clk) begin
    if (vld_p1 & ~clear) begin
      for (int i = 0; i < OUT_N; i++) begin
        score_out[i*SW +: SW] <= score_c[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_binary_linear_xnor.sv
module tb_binary_linear_xnor;

  localparam int IN_W      = 64;
  localparam int OUT_N     = 16;
  localparam int NUM_BLK   = 4;
  localparam int NUM_STEPS = 30;
  localparam int SW        = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  clear = 1'b0;
  logic [IN_W-1:0]       data_in = '0;
  logic                  data_in_valid = 1'b0;
  logic [1:0]            block_sel = '0;
  logic                  w_we = 1'b0;
  logic [1:0]            w_addr = '0;
  logic [OUT_N*IN_W-1:0] w_data = '0;
  logic [OUT_N-1:0]      data_out;
  logic                  data_out_valid;
  logic [4:0]            step_cnt;
  logic                  done;
`ifdef BINARY_LINEAR_SCORE_OUT_EN
  logic [OUT_N*SW-1:0]   score_out;
`endif

  binary_linear_xnor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .block_sel      (block_sel),
    .w_we           (w_we),
    .w_addr         (w_addr),
    .w_data         (w_data),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .step_cnt       (step_cnt),
    .done           (done)
`ifdef BINARY_LINEAR_SCORE_OUT_EN
    ,
    .score_out      (score_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_N-1:0]    d;
    logic [OUT_N*SW-1:0] sc;
    logic [31:0]         cyc;
    logic                done;
  } exp_t;

  exp_t                  sbq[$];
  logic [OUT_N*IN_W-1:0] mw [NUM_BLK];
  int                    mcnt = 0;
  int                    cyc = 0;
  int                    n_checks = 0;
  int                    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [IN_W-1:0] d, input logic [1:0] sel);
    exp_t e;
    logic [IN_W-1:0] row;
    int pop;
    int s;
    e = '0;
    for (int i = 0; i < OUT_N; i++) begin
      row = mw[sel][i*IN_W +: IN_W];
      pop = $countones(~(d ^ row));
      s   = 2 * pop - IN_W;
      e.d[i] = (s > 0);
      e.sc[i*SW +: SW] = SW'(s);
    end
    return e;
  endfunction

  task automatic drive(input logic [IN_W-1:0] d, input logic [1:0] sel, input bit clr);
    exp_t e;
    data_in       = d;
    block_sel     = sel;
    data_in_valid = 1'b1;
    clear         = clr;
    if (!clr && mcnt < NUM_STEPS) begin
      e = model(d, sel);
      mcnt++;
      e.done = (mcnt == NUM_STEPS);
      e.cyc  = 32'(cyc + 3);
      sbq.push_back(e);
    end
    if (clr) mcnt = 0;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    clear         = 1'b0;
    w_we          = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic write_blk(input logic [1:0] addr, input logic [OUT_N*IN_W-1:0] data);
    w_we   = 1'b1;
    w_addr = addr;
    w_data = data;
    @(posedge clk); #1;
    w_we     = 1'b0;
    mw[addr] = data;
  endtask

  function automatic logic [OUT_N*IN_W-1:0] rand_blk();
    logic [OUT_N*IN_W-1:0] v;
    for (int j = 0; j < OUT_N*IN_W/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [IN_W-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  // Output monitor: compares every data_out_valid against the scoreboard
  // and flags outputs that arrive late, early or unexpectedly.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sbq.size() > 0 && int'(sbq[0].cyc) < cyc) begin
        check("missing_vld", 128'(data_out_valid), 128'(1));
        void'(sbq.pop_front());
      end
      if (data_out_valid) begin
        if (sbq.size() == 0) begin
          check("unexp_vld", 128'(1), 128'(0));
        end else begin
          e = sbq.pop_front();
          check("latency", 128'(cyc), 128'(e.cyc));
          check("data_out", 128'(data_out), 128'(e.d));
          check("done_at_vld", 128'(done), 128'(e.done));
`ifdef BINARY_LINEAR_SCORE_OUT_EN
          check("score_out", 128'(score_out), 128'(e.sc));
`endif
        end
      end
    end
  end

  initial begin
    logic [OUT_N*IN_W-1:0] blk;
    logic [OUT_N*IN_W-1:0] new2;
    logic [IN_W-1:0]       v;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 128'(data_out), 128'(0));
    check("rst_valid", 128'(data_out_valid), 128'(0));
    check("rst_step_cnt", 128'(step_cnt), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    idle(1);

    blk = rand_blk();
    blk[IN_W-1:0] = '0;
    write_blk(2'd0, blk);
    write_blk(2'd1, '1);
    write_blk(2'd2, rand_blk());
    write_blk(2'd3, rand_blk());

    // All-ones weights and activations: every neuron scores +64.
    drive('1, 2'd1, 1'b0);
    idle(4);

    // Row 0 of block 0 is zero: 32 zero bits is a tie, 33 gives score 2.
    drive(64'hFFFF_FFFF_0000_0000, 2'd0, 1'b0);
    drive(64'hFFFF_FFFE_0000_0000, 2'd0, 1'b0);
    idle(4);

    // Same-cycle write and read of block 2 returns the old weights.
    v      = rand_vec();
    new2   = rand_blk();
    w_we   = 1'b1;
    w_addr = 2'd2;
    w_data = new2;
    drive(v, 2'd2, 1'b0);
    mw[2] = new2;
    drive(v, 2'd2, 1'b0);
    idle(4);
    check("step_cnt_mid", 128'(step_cnt), 128'(5));

    // Fill the sequence back-to-back up to NUM_STEPS.
    for (int i = 5; i < NUM_STEPS; i++) drive(rand_vec(), 2'($urandom_range(0, 3)), 1'b0);
    idle(4);
    check("step_cnt_full", 128'(step_cnt), 128'(NUM_STEPS));
    check("done_set", 128'(done), 128'(1));

    // Input beyond NUM_STEPS is dropped.
    drive(rand_vec(), 2'd1, 1'b0);
    idle(4);
    check("step_cnt_sat", 128'(step_cnt), 128'(NUM_STEPS));
    check("done_sticky", 128'(done), 128'(1));

    // Clear wins over a simultaneous valid input.
    drive(rand_vec(), 2'd0, 1'b1);
    check("clr_step_cnt", 128'(step_cnt), 128'(0));
    check("clr_done", 128'(done), 128'(0));
    idle(4);
    check("clr_dropped", 128'(step_cnt), 128'(0));
    drive(rand_vec(), 2'd3, 1'b0);
    idle(4);
    check("post_clr_cnt", 128'(step_cnt), 128'(1));

    // Reset with two inputs in flight discards them.
    drive(rand_vec(), 2'd1, 1'b0);
    drive(rand_vec(), 2'd2, 1'b0);
    rst_n = 1'b0;
    sbq.delete();
    mcnt = 0;
    #2;
    check("mid_rst_data_out", 128'(data_out), 128'(0));
    check("mid_rst_valid", 128'(data_out_valid), 128'(0));
    check("mid_rst_step", 128'(step_cnt), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);
    check("post_rst_data_out", 128'(data_out), 128'(0));
    drive(rand_vec(), 2'd2, 1'b0);
    idle(4);
    check("post_rst_cnt", 128'(step_cnt), 128'(1));

    check("sb_empty", 128'(sbq.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/binary_linear_xnor.md
Name: binary_linear_xnor

Overview:
Parametrised binarised fully-connected layer for the transformer FFN/attention intermediate path. Each input vector of IN_W sign bits is XNOR-popcounted against OUT_N weight rows from a selectable block of an internal, writable weight RAM. Each signed score is thresholded to one output bit. A step counter tracks NUM_STEPS tokens and raises done.

Parameters:
IN_W, 64, input vector width in bits (even, >=8)
OUT_N, 16, output neurons per pass
NUM_BLK, 4, weight blocks held in RAM
NUM_STEPS, 30, tokens per sequence before done
THRESH, 0, signed score threshold; bit=1 when score > THRESH

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clear  in  1  sync clear of step counter, done, pipeline valids
data_in  in  IN_W  binarised activations (1=+1, 0=-1)
data_in_valid  in  1  input qualifier, no backpressure
block_sel  in  clog2(NUM_BLK)  weight block for this input
w_we  in  1  weight write enable
w_addr  in  clog2(NUM_BLK)  weight block to write
w_data  in  OUT_N*IN_W  weight rows; row i = bits [i*IN_W +: IN_W]
data_out  out  OUT_N  binarised neuron outputs
data_out_valid  out  1  data_out qualifier, one cycle per accepted input
step_cnt  out  clog2(NUM_STEPS+1)  accepted inputs so far
done  out  1  sticky sequence-complete flag

Behaviour:
- Reset: data_out=0, data_out_valid=0, step_cnt=0, done=0, all pipeline valids 0. Weight RAM is not reset.
- Accept: an input is accepted when data_in_valid=1 and step_cnt<NUM_STEPS. Acceptance increments step_cnt, which saturates at NUM_STEPS. Inputs arriving with step_cnt==NUM_STEPS are dropped: no output, no count.
- Pipeline (latency 3, throughput 1/cycle):
  - S1: sync RAM read of block_sel; data_in and valid registered.
  - S2: per-neuron XNOR and popcount, registered.
  - S3: threshold compare, registered into data_out/data_out_valid.
  - data_out_valid rises exactly 3 cycles after the accepting edge.
  - data_out holds its value when no output is valid.
- Arithmetic:
  - pop width = clog2(IN_W+1).
  - score = 2*pop - IN_W, computed signed with width clog2(IN_W+1)+1.
  - bit = (score > THRESH), signed comparison. The default threshold requires pop > IN_W/2; a tie yields 0.
- Block select out of range (block_sel>=NUM_BLK): the input is still accepted and counted, and all output bits are forced to 0.
- Weight write:
  - w_we writes the whole block at w_addr.
  - A read of the same block in the same cycle returns old data (read-first).
  - An out-of-range w_addr write is ignored.
- done:
  - Sets on the cycle data_out_valid is asserted for the NUM_STEPS-th accepted input, i.e. registered together with the last output.
  - Stays high until clear or reset.
- clear:
  - Zeroes step_cnt, done and all pipeline valids next edge; weight RAM is unaffected.
  - clear has priority over a simultaneous data_in_valid, which is dropped.
- Reset mid-pipeline: in-flight results are discarded; no data_out_valid is produced after reset release for pre-reset inputs.

Optional Feature:
- Macro BINARY_LINEAR_SCORE_OUT_EN.
- When defined:
  - Adds output score_out, width OUT_N*(clog2(IN_W+1)+1). It carries the signed scores, neuron i at [i*SW +: SW], registered alongside data_out with the same valid.
  - Out-of-range block scores are 0.
- When undefined: the port and its registers are absent; behaviour is otherwise identical.

Decomposition:
- Package binary_linear_pkg holds:
  - clog2 function;
  - pop/score width localparam helpers;
  - signed score typedef for default IN_W.
- One sub-module, xnor_popcount:
  - takes an IN_W-bit weight row and the IN_W-bit activation, and outputs pop;
  - uses a balanced adder tree and is combinational;
  - instantiated OUT_N times in S2.

Test Plan:
- Write block 1 all-ones; data_in all-ones, block_sel=1 -> 3 cycles later data_out=16'hFFFF, data_out_valid=1 for 1 cycle; score_out each =64.
- Block 0 row0 = 64'h0; data_in with exactly 32 zero bits -> out bit0=0 (tie); with 33 zero bits -> bit0=1, score=2.
- 30 back-to-back valid inputs -> 30 valids, step_cnt=30, done=1 on the 30th valid cycle; 31st input -> no valid, step_cnt stays 30.
- clear asserted with data_in_valid=1 after done -> step_cnt=0, done=0, that input dropped; next input processed normally.
- w_we to block 2 the same cycle data_in reads block 2 -> output uses old weights; the next input uses new weights.
- rst_n low for 1 cycle with 2 inputs in flight -> all outputs 0, no data_out_valid after release until a new input is accepted.
